// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: queues ALU commands and drives them into an external combinational ALU one at a time.
// Latency: rsp_valid rises 4 edges after a legal command is accepted and 2 edges after an illegal one (FIFO empty); one result per 4 cycles.
// Backpressure: cmd_ready (registered) drops when the FIFO is full; the rsp_* outputs hold while rsp_valid && !rsp_ready.
// Optional: define ALU_SELF_CHECK_EN to add a golden model and the sticky chk_fail output.
module alu_op_sequencer #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [2:0]       cmd_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_opcode,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_carry,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_res,
    output logic             rsp_carry,
    output logic             rsp_err,
    output logic             busy
`ifdef ALU_SELF_CHECK_EN
    ,
    output logic             chk_fail
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [2:0]       op;
    } cmd_t;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_CAPTURE = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    cmd_t             r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_nxt;
    logic             r_cmd_ready;
    logic             r_vis;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [2:0]       r_alu_op;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_res;
    logic             r_rsp_carry;
    logic             r_rsp_err;
    logic             w_push;
    logic             w_pop;
    logic             w_ld_alu;
    logic             w_ld_illegal;
    logic             w_ld_capture;
    logic             w_rsp_done;
    logic             w_cap_err;
    logic             w_head_illegal;
    cmd_t             w_head;

    assign w_push         = cmd_valid && r_cmd_ready;
    assign w_head         = r_mem[r_rd_ptr];
    assign w_head_illegal = (w_head.op[2:1] == 2'b11);

    // Command storage; contents need no reset because the pointers gate every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cmd_a, cmd_b, cmd_op};
        end
    end

    // Occupancy after this cycle's push/pop.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // FIFO pointers, count and registered ready. r_vis lags occupancy by one cycle so a
    // freshly written entry spends one cycle in the FIFO before the sequencer may pop it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_cmd_ready <= 1'b0;
            r_vis       <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count     <= w_count_nxt;
            r_cmd_ready <= (w_count_nxt != FULL);
            r_vis       <= (r_count != '0);
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Sequencer next state and datapath load strobes.
    always_comb begin
        w_state_nxt  = r_state;
        w_pop        = 1'b0;
        w_ld_alu     = 1'b0;
        w_ld_illegal = 1'b0;
        w_ld_capture = 1'b0;
        w_rsp_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_vis && (r_count != '0)) begin
                    w_pop = 1'b1;
                    if (w_head_illegal) begin
                        w_ld_illegal = 1'b1;
                        w_state_nxt  = S_RESP;
                    end else begin
                        w_ld_alu    = 1'b1;
                        w_state_nxt = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                w_state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                w_ld_capture = 1'b1;
                w_state_nxt  = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_rsp_done  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ALU operand registers; only legal commands re-drive the ALU.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_alu_op <= '0;
        end else if (w_ld_alu) begin
            r_alu_a  <= w_head.a;
            r_alu_b  <= w_head.b;
            r_alu_op <= w_head.op;
        end
    end

    // Response registers: loaded on an illegal pop or in CAPTURE, held until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_res   <= '0;
            r_rsp_carry <= 1'b0;
            r_rsp_err   <= 1'b0;
        end else if (w_ld_illegal) begin
            r_rsp_valid <= 1'b1;
            r_rsp_res   <= '0;
            r_rsp_carry <= 1'b0;
            r_rsp_err   <= 1'b1;
        end else if (w_ld_capture) begin
            r_rsp_valid <= 1'b1;
            r_rsp_res   <= alu_res;
            r_rsp_carry <= alu_carry;
            r_rsp_err   <= w_cap_err;
        end else if (w_rsp_done) begin
            r_rsp_valid <= 1'b0;
        end
    end

`ifdef ALU_SELF_CHECK_EN
    logic [WIDTH:0] w_gold;
    logic           w_mismatch;
    logic           r_chk_fail;

    // Golden {carry,res} for the operands currently driven into the ALU.
    always_comb begin
        w_gold = '0;
        case (r_alu_op)
            3'b000:  w_gold = {1'b0, r_alu_a} + {1'b0, r_alu_b};
            3'b001:  w_gold = {(r_alu_a < r_alu_b), r_alu_a - r_alu_b};
            3'b010:  w_gold = {1'b0, r_alu_a & r_alu_b};
            3'b011:  w_gold = {1'b0, r_alu_a | r_alu_b};
            3'b100:  w_gold = {1'b0, r_alu_a ^ r_alu_b};
            3'b101:  w_gold = {1'b0, ~r_alu_a};
            default: w_gold = '0;
        endcase
    end

    assign w_mismatch = (w_gold != {alu_carry, alu_res});
    assign w_cap_err  = w_mismatch;

    // Sticky self-check flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chk_fail <= 1'b0;
        end else if (w_ld_capture && w_mismatch) begin
            r_chk_fail <= 1'b1;
        end
    end

    assign chk_fail = r_chk_fail;
`else
    assign w_cap_err = 1'b0;
`endif

    assign cmd_ready  = r_cmd_ready;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_opcode = r_alu_op;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_res    = r_rsp_res;
    assign rsp_carry  = r_rsp_carry;
    assign rsp_err    = r_rsp_err;
    assign busy       = (r_state != S_IDLE) || (r_count != '0);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: models the external ALU, predicts every response from the
// accepted commands with plain arithmetic, and checks responses, ALU drive and stability each cycle.
module tb_alu_op_sequencer;

    localparam int W = 4;
    localparam int M = 16;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
        logic [3:0] res;
        logic       carry;
        logic       err;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [2:0] cmd_op;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_opcode;
    logic [3:0] alu_res;
    logic       alu_carry;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_res;
    logic       rsp_carry;
    logic       rsp_err;
    logic       busy;
`ifdef ALU_SELF_CHECK_EN
    logic       chk_fail;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int n_rsp    = 0;
    int lat;
    int n0;
    logic corrupt     = 1'b0;
    logic exp_corrupt = 1'b0;
    logic rnd_done    = 1'b0;

    exp_t        q[$];
    exp_t        mon_head;
    logic        prev_hold = 1'b0;
    logic [5:0]  prev_rsp  = '0;
    logic [10:0] last_legal = '0;
    logic [3:0]  sweep_exp [6];

    alu_op_sequencer #(.WIDTH(4), .DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_op     (cmd_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_res    (alu_res),
        .alu_carry  (alu_carry),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_res    (rsp_res),
        .rsp_carry  (rsp_carry),
        .rsp_err    (rsp_err),
        .busy       (busy)
`ifdef ALU_SELF_CHECK_EN
        ,
        .chk_fail   (chk_fail)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected response for one command, straight from the opcode table.
    function automatic exp_t model(input logic [3:0] a, input logic [3:0] b,
                                   input logic [2:0] op, input logic bad);
        exp_t e;
        int ai;
        int bi;
        int s;
        ai = int'(a);
        bi = int'(b);
        e.a = a; e.b = b; e.op = op; e.carry = 1'b0; e.err = 1'b0;
        case (op)
            3'd0: begin s = ai + bi; if (s >= M) begin s = s - M; e.carry = 1'b1; end end
            3'd1: begin s = ai - bi; if (s < 0) begin s = s + M; e.carry = 1'b1; end end
            3'd2: s = ai & bi;
            3'd3: s = ai | bi;
            3'd4: s = ai ^ bi;
            3'd5: s = (M - 1) - ai;
            default: begin s = 0; e.err = 1'b1; end
        endcase
        e.res = 4'(s);
        if (bad && !e.err) begin
            e.res = e.res ^ 4'b0001;
            e.err = 1'b1;
        end
        return e;
    endfunction

    // External combinational ALU; 'corrupt' flips the result LSB.
    always_comb begin
        exp_t t;
        t = model(alu_a, alu_b, alu_opcode, 1'b0);
        alu_res   = t.res ^ {3'b000, corrupt};
        alu_carry = t.carry;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    task automatic timeout(input string name);
        n_checks++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Present a command and hold it until accepted; returns just after the accepting edge.
    task automatic push(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        logic ok;
        ok = 1'b0;
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        if (!ok) timeout("push");
    endtask

    // Count edges until rsp_valid is seen.
    task automatic wait_rsp(output int edges);
        edges = 0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) begin edges = i; break; end
        end
        if (edges == 0) timeout("wait_rsp");
    endtask

    task automatic wait_idle();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            if (!busy && !rsp_valid) begin done = 1'b1; break; end
        end
        if (!done) timeout("wait_idle");
    endtask

    // Per-cycle scoreboard: order, values, ALU drive, stability under backpressure, reset state.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            last_legal = '0;
            prev_hold  = 1'b0;
            check("reset_outputs", 32'({cmd_ready, alu_a, alu_b, alu_opcode, rsp_valid,
                                        rsp_res, rsp_carry, rsp_err, busy}), 32'd0);
`ifdef ALU_SELF_CHECK_EN
            check("reset_chk_fail", 32'(chk_fail), 32'd0);
`endif
        end else begin
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    check("rsp_spurious", 32'(rsp_valid), 32'd0);
                end else begin
                    mon_head = q[0];
                    check("rsp_fields", 32'({rsp_res, rsp_carry, rsp_err}),
                          32'({mon_head.res, mon_head.carry, mon_head.err}));
                    if (mon_head.op[2:1] != 2'b11)
                        check("alu_drive", 32'({alu_a, alu_b, alu_opcode}),
                              32'({mon_head.a, mon_head.b, mon_head.op}));
                    else
                        check("alu_hold", 32'({alu_a, alu_b, alu_opcode}), 32'(last_legal));
                    if (rsp_ready) begin
                        void'(q.pop_front());
                        if (mon_head.op[2:1] != 2'b11)
                            last_legal = {mon_head.a, mon_head.b, mon_head.op};
                    end
                end
                if (prev_hold) check("rsp_stable", 32'({rsp_res, rsp_carry, rsp_err}), 32'(prev_rsp));
                if (rsp_ready) n_rsp++;
            end else if (prev_hold) begin
                check("rsp_held_valid", 32'(rsp_valid), 32'd1);
            end
            prev_hold = rsp_valid && !rsp_ready;
            prev_rsp  = {rsp_res, rsp_carry, rsp_err};
            if (cmd_valid && cmd_ready) q.push_back(model(cmd_a, cmd_b, cmd_op, exp_corrupt));
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sweep_exp[0] = 4'b1001; sweep_exp[1] = 4'b0011; sweep_exp[2] = 4'b1010;
        sweep_exp[3] = 4'b1111; sweep_exp[4] = 4'b0101; sweep_exp[5] = 4'b0001;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; rsp_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);

        // First command: ADD 1110 + 1011
        rsp_ready = 1'b1;
        push(4'b1110, 4'b1011, 3'b000);
        wait_rsp(lat);
        check("add_latency", 32'(lat), 32'd4);
        check("add_res", 32'(rsp_res), 32'(4'b1001));
        check("add_carry", 32'(rsp_carry), 32'd1);
        check("add_err", 32'(rsp_err), 32'd0);
        check("add_alu_drive", 32'({alu_a, alu_b, alu_opcode}), 32'({4'b1110, 4'b1011, 3'b000}));
        wait_idle();

        // Opcode sweep with the same operands
        for (int op = 1; op <= 5; op++) begin
            push(4'b1110, 4'b1011, 3'(op));
            wait_rsp(lat);
            check("sweep_latency", 32'(lat), 32'd4);
            check("sweep_res", 32'(rsp_res), 32'(sweep_exp[op]));
            check("sweep_carry", 32'(rsp_carry), 32'd0);
            wait_idle();
        end

        // Lone illegal opcode: fast path, ALU left alone
        push(4'd3, 4'd4, 3'b110);
        wait_rsp(lat);
        check("illegal_latency", 32'(lat), 32'd2);
        check("illegal_rsp", 32'({rsp_res, rsp_carry, rsp_err}), 32'({4'b0000, 1'b0, 1'b1}));
        check("illegal_alu_hold", 32'({alu_a, alu_b, alu_opcode}), 32'({4'b1110, 4'b1011, 3'b101}));
        wait_idle();

        // Illegal opcode between two ADDs
        n0 = n_rsp;
        push(4'd1, 4'd2, 3'b000);
        push(4'd5, 4'd6, 3'b111);
        push(4'd7, 4'd7, 3'b000);
        wait_idle();
        check("illegal_seq_count", 32'(n_rsp - n0), 32'd3);

        // Backpressure: 5 commands with rsp_ready low
        rsp_ready = 1'b0;
        n0 = n_rsp;
        for (int i = 0; i < 5; i++)
            push(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 5)));
        check("bp_cmd_ready_full", 32'(cmd_ready), 32'd0);
        begin
            logic seen_ready;
            seen_ready = 1'b0;
            repeat (10) begin
                @(posedge clk); #1;
                if (cmd_ready || !rsp_valid) seen_ready = 1'b1;
            end
            check("bp_stall_stable", 32'({seen_ready, rsp_valid}), 32'({1'b0, 1'b1}));
        end
        rsp_ready = 1'b1;
        wait_idle();
        check("bp_drain_count", 32'(n_rsp - n0), 32'd5);

        // Random traffic with random backpressure
        n0 = n_rsp;
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    push(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    rsp_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        rsp_ready = 1'b1;
        wait_idle();
        check("random_count", 32'(n_rsp - n0), 32'd300);

        // Reset during SETTLE with 3 entries queued
        rsp_ready = 1'b0;
        push(4'd9, 4'd3, 3'b001);
        wait_rsp(lat);
        for (int i = 0; i < 4; i++)
            push(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 5)));
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        check("midrst_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_outputs", 32'({rsp_valid, busy, cmd_ready}), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        n0 = n_rsp;
        repeat (20) begin @(posedge clk); #1; end
        check("midrst_no_stale", 32'(n_rsp - n0), 32'd0);
        check("midrst_idle", 32'({busy, cmd_ready}), 32'({1'b0, 1'b1}));

`ifdef ALU_SELF_CHECK_EN
        // Self-check: one corrupted ALU result
        check("chk_fail_clear", 32'(chk_fail), 32'd0);
        corrupt = 1'b1;
        exp_corrupt = 1'b1;
        push(4'd1, 4'd1, 3'b000);
        exp_corrupt = 1'b0;
        wait_rsp(lat);
        check("chk_rsp", 32'({rsp_res, rsp_err}), 32'({4'b0011, 1'b1}));
        check("chk_fail_set", 32'(chk_fail), 32'd1);
        wait_idle();
        corrupt = 1'b0;
        push(4'd2, 4'd2, 3'b000);
        wait_rsp(lat);
        check("chk_clean_err", 32'(rsp_err), 32'd0);
        check("chk_fail_sticky", 32'(chk_fail), 32'd1);
        wait_idle();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
